seq_frame_ctrl: RTL and testbench

SEQ_FRAME_CTRL -- requirements
Module: seq_frame_ctrl

---
 rtl/seq_frame_pkg.sv | 13 +
 rtl/seq_frame_shift.sv | 34 +++
 rtl/seq_frame_ctrl.sv | 115 +++++++++++
 tb/tb_seq_frame_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_frame_pkg.sv
// Shared types and default sizing for the serial frame matcher.
package seq_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REPORT  = 2'd2
  } state_t;

  localparam int DEF_FRAME_LEN = 6;
  localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/seq_frame_shift.sv
// Frame shift register plus bit counter; last flags the final bit position of a frame.
module seq_frame_shift
  import seq_frame_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 shift_en,
  input  logic                 bit_in,
  output logic [FRAME_LEN-1:0] frame,
  output logic                 last
);

  localparam int BW = $clog2(FRAME_LEN);
  localparam logic [BW-1:0] LAST_IDX = BW'(FRAME_LEN - 1);

  logic [BW-1:0] bit_cnt;

  // Counter wraps on the final bit so the next frame starts from zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      bit_cnt <= '0;
      frame   <= '0;
    end else if (shift_en) begin
      frame   <= {frame[FRAME_LEN-2:0], bit_in};
      bit_cnt <= last ? '0 : bit_cnt + 1'b1;
    end
  end

  assign last = (bit_cnt == LAST_IDX);

endmodule

// File: rtl/seq_frame_ctrl.sv
// Serial frame matcher: collects FRAME_LEN-bit frames and pulses match/not_match.
// Optional matched-frame counter enabled by defining SEQ_CNT_EN.
module seq_frame_ctrl
  import seq_frame_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [FRAME_LEN-1:0] cfg_pattern,
  input  logic                 data_valid,
  input  logic                 data,
  output logic                 ready,
  output logic                 busy,
  output logic                 match,
  output logic                 not_match
`ifdef SEQ_CNT_EN
  ,
  output logic [CNT_W-1:0]     match_cnt
`endif
);

  if (FRAME_LEN < 2 || FRAME_LEN > 16) begin : g_bad_len
    $error("FRAME_LEN out of range");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("CNT_W must be positive");
  end

  state_t                 state, state_nxt;
  logic [FRAME_LEN-1:0]   pattern;
  logic [FRAME_LEN-1:0]   frame;
  logic [FRAME_LEN-1:0]   frame_cand;
  logic                   last;
  logic                   accept;
  logic                   start_ok;
  logic                   frame_done;
  logic                   frame_eq;

  seq_frame_shift #(.FRAME_LEN(FRAME_LEN)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok | stop),
    .shift_en (accept),
    .bit_in   (data),
    .frame    (frame),
    .last     (last)
  );

  // The completed frame is judged on the bit arriving this cycle, so the
  // pulse lands exactly one cycle after the final bit.
  assign frame_cand = {frame[FRAME_LEN-2:0], data};
  assign frame_eq   = (frame_cand == pattern);

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    start_ok   = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          start_ok  = 1'b1;
          state_nxt = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        accept = data_valid && !stop;
        if (accept && last) begin
          frame_done = 1'b1;
          state_nxt  = ST_REPORT;
        end
      end
      ST_REPORT: state_nxt = ST_COLLECT;
      default:   state_nxt = ST_IDLE;
    endcase
    if (stop) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pattern   <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      match     <= 1'b0;
      not_match <= 1'b0;
    end else begin
      state     <= state_nxt;
      ready     <= (state_nxt == ST_COLLECT);
      busy      <= (state_nxt != ST_IDLE);
      match     <= frame_done && frame_eq;
      not_match <= frame_done && !frame_eq;
      if (start_ok) pattern <= cfg_pattern;
    end
  end

`ifdef SEQ_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      match_cnt <= '0;
    end else if (frame_done && frame_eq) begin
      match_cnt <= sat_inc(match_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_seq_frame_ctrl.sv
// Self-checking bench for seq_frame_ctrl against a queue-based frame model.
module tb_seq_frame_ctrl;

  localparam int FL = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, start, stop, data_valid, data;
  logic [FL-1:0] cfg_pattern;
  logic          ready, busy, match, not_match;
`ifdef SEQ_CNT_EN
  logic [CW-1:0] match_cnt;
`endif

  always #5 clk = ~clk;

  seq_frame_ctrl #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .cfg_pattern (cfg_pattern),
    .data_valid  (data_valid),
    .data        (data),
    .ready       (ready),
    .busy        (busy),
    .match       (match),
    .not_match   (not_match)
`ifdef SEQ_CNT_EN
    ,
    .match_cnt   (match_cnt)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: armed flag, report-cycle flag, and a queue of received bits.
  bit            m_armed = 0;
  bit            m_rep   = 0;
  bit            m_match = 0;
  bit            m_nm    = 0;
  bit            mq[$];
  logic [FL-1:0] m_pat   = '0;
  int            m_cnt   = 0;

  function automatic logic [FL-1:0] pack_q();
    logic [FL-1:0] v = '0;
    foreach (mq[i]) v = {v[FL-2:0], mq[i]};
    return v;
  endfunction

  task automatic model_step();
    m_match = 0;
    m_nm    = 0;
    if (rst) begin
      m_armed = 0; m_rep = 0; mq.delete(); m_pat = '0; m_cnt = 0;
    end else if (stop) begin
      m_armed = 0; m_rep = 0; mq.delete();
    end else if (!m_armed) begin
      if (start) begin
        m_armed = 1; m_pat = cfg_pattern; mq.delete(); m_cnt = 0;
      end
    end else if (m_rep) begin
      m_rep = 0;
    end else if (data_valid) begin
      mq.push_back(data);
      if (mq.size() == FL) begin
        if (pack_q() == m_pat) begin
          m_match = 1;
          if (m_cnt < (1 << CW) - 1) m_cnt++;
        end else begin
          m_nm = 1;
        end
        m_rep = 1;
        mq.delete();
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic p, input logic v,
                     input logic d, input logic [FL-1:0] pat);
    rst = r; start = s; stop = p; data_valid = v; data = d; cfg_pattern = pat;
    model_step();
    @(posedge clk);
    #1;
    chk("ready", ready, m_armed && !m_rep);
    chk("busy", busy, m_armed);
    chk("match", match, m_match);
    chk("not_match", not_match, m_nm);
`ifdef SEQ_CNT_EN
    chk("match_cnt", match_cnt, m_cnt);
`endif
  endtask

  // hold=1 keeps each bit on the bus until it is accepted (ready high).
  task automatic send_frame(input logic [FL-1:0] bits, input bit hold);
    for (int i = FL - 1; i >= 0; i--) begin
      if (hold) begin
        logic acc;
        int   tries = 0;
        do begin
          acc = ready;
          cyc(0, 0, 0, 1, bits[i], '0);
          tries++;
        end while (!acc && tries < 8);
        if (!acc) chk("hold_timeout", 0, 1);
      end else begin
        cyc(0, 0, 0, 1, bits[i], '0);
      end
    end
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, '0);
  endtask

  initial begin
    logic [FL-1:0] p0;
    p0 = 6'b011100;

    cyc(1, 0, 0, 0, 0, '0);
    cyc(1, 1, 0, 1, 1, '1);
    chk("reset_ready", ready, 0);
    chk("reset_busy", busy, 0);
    idle_cyc();

    // Basic match.
    cyc(0, 1, 0, 0, 0, p0);
    send_frame(p0, 0);
    chk("req33_match", match, 1);
    chk("req33_ready", ready, 0);
`ifdef SEQ_CNT_EN
    chk("req33_cnt", match_cnt, 1);
`endif
    idle_cyc();
    chk("req33_ready_back", ready, 1);

    // Mismatch; also a start with another pattern while collecting is ignored.
    cyc(0, 1, 0, 0, 0, 6'b111100);
    send_frame(6'b111100, 0);
    chk("req34_nm", not_match, 1);
    chk("req34_match", match, 0);
`ifdef SEQ_CNT_EN
    chk("req34_cnt", match_cnt, 1);
`endif

    // Valid held through REPORT, two back-to-back frames.
    cyc(0, 0, 1, 0, 0, '0);
    cyc(0, 1, 0, 0, 0, p0);
    send_frame(p0, 1);
    send_frame(p0, 1);
    idle_cyc();
`ifdef SEQ_CNT_EN
    chk("req35_cnt", match_cnt, 2);
`endif

    // Abort after 3 bits, restart.
    cyc(0, 0, 1, 0, 0, '0);
    cyc(0, 1, 0, 0, 0, p0);
    cyc(0, 0, 0, 1, 0, '0);
    cyc(0, 0, 0, 1, 1, '0);
    cyc(0, 0, 0, 1, 1, '0);
    cyc(0, 0, 1, 0, 0, '0);
    chk("req36_busy", busy, 0);
    cyc(0, 1, 0, 0, 0, p0);
    send_frame(p0, 0);
    chk("req36_match", match, 1);
`ifdef SEQ_CNT_EN
    chk("req36_cnt", match_cnt, 1);
`endif

    // Stop coinciding with the final bit suppresses the pulse.
    idle_cyc();
    for (int i = FL - 1; i >= 1; i--) cyc(0, 0, 0, 1, p0[i], '0);
    cyc(0, 0, 1, 1, p0[0], '0);
    chk("stop_last_match", match, 0);
    chk("stop_last_nm", not_match, 0);

    // Start and stop together in idle: stop wins.
    cyc(0, 1, 1, 0, 0, p0);
    chk("start_stop_busy", busy, 0);

    // Saturation.
    cyc(0, 1, 0, 0, 0, p0);
    for (int k = 0; k < 256; k++) send_frame(p0, 1);
    idle_cyc();
`ifdef SEQ_CNT_EN
    chk("req37_sat", match_cnt, 255);
`endif
    send_frame(p0, 1);
    idle_cyc();
`ifdef SEQ_CNT_EN
    chk("req37_hold", match_cnt, 255);
`endif
    cyc(0, 0, 1, 0, 0, '0);
    cyc(0, 1, 0, 0, 0, p0);
`ifdef SEQ_CNT_EN
    chk("req37_clear", match_cnt, 0);
`endif

    // Reset mid-frame.
    for (int i = FL - 1; i >= 2; i--) cyc(0, 0, 0, 1, p0[i], '0);
    cyc(1, 1, 0, 1, 1, p0);
    chk("req38_ready", ready, 0);
    chk("req38_busy", busy, 0);
    chk("req38_match", match, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, '0);
    chk("req38_ignored", ready, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic r, s, p, v, d;
      logic [FL-1:0] pat;
      r   = ($urandom % 300) == 0;
      s   = ($urandom % 12) == 0;
      p   = ($urandom % 60) == 0;
      v   = ($urandom % 4) != 0;
      pat = FL'($urandom);
      // Bias data toward the armed pattern so matches actually occur.
      if (($urandom % 3) != 0 && mq.size() < FL) d = m_pat[FL - 1 - mq.size()];
      else d = 1'($urandom);
      cyc(r, s, p, v, d, pat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
